// File: rtl/menu_screen_ctrl.sv
// Game-menu renderer for the 96x64 OLED pixel path: N_ITEMS rows, blinking cursor,
// highlight band, external label overlay and a valid/ack selection handoff.
module menu_screen_ctrl #(
    parameter int          N_ITEMS      = 4,
    parameter int          DEFAULT_ITEM = 0,
    parameter int          ITEM_Y0      = 28,
    parameter int          ITEM_PITCH   = 8,
    parameter int          ITEM_H       = 5,
    parameter int          CURSOR_X     = 18,
    parameter int          HL_X0        = 20,
    parameter int          HL_X1        = 83,
    parameter int          BLINK_FRAMES = 16,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [15:0] FG_COLOUR    = 16'hFFFF,
    parameter logic [15:0] HL_COLOUR    = 16'h001F,
    parameter logic [15:0] BG_COLOUR    = 16'h0000,
    parameter logic [15:0] CUR_COLOUR   = 16'h07E0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  x,
    input  logic [5:0]  y,
    input  logic        label_px,
    input  logic        frame_begin,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    input  logic        sel_ack,
    output logic [15:0] oled_data,
    output logic [2:0]  cursor_idx,
    output logic        sel_valid,
    output logic [2:0]  sel_idx
);

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam int CW = 10;

    localparam logic [2:0]    LAST_ITEM  = 3'(N_ITEMS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    typedef enum logic [1:0] {NAV, FLASH, HOLD} state_t;

    state_t        state;
    logic          blink_on;
    logic [BW-1:0] blink_cnt;
    logic          flash_on;
    logic [FW-1:0] flash_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= NAV;
            cursor_idx <= 3'(DEFAULT_ITEM);
            blink_on   <= 1'b1;
            blink_cnt  <= '0;
            flash_on   <= 1'b0;
            flash_cnt  <= '0;
            sel_valid  <= 1'b0;
            sel_idx    <= 3'd0;
        end else begin
            case (state)
                NAV: begin
                    if (btn_sel) begin
                        state     <= FLASH;
                        sel_idx   <= cursor_idx;
                        flash_cnt <= '0;
                        flash_on  <= 1'b1;
                    end else if (btn_up != btn_down) begin
                        if (btn_up)
                            cursor_idx <= (cursor_idx == 3'd0) ? LAST_ITEM : cursor_idx - 3'd1;
                        else
                            cursor_idx <= (cursor_idx == LAST_ITEM) ? 3'd0 : cursor_idx + 3'd1;
                        blink_on  <= 1'b1;
                        blink_cnt <= '0;
                    end else if (frame_begin) begin
                        if (blink_cnt == BLINK_LAST) begin
                            blink_cnt <= '0;
                            blink_on  <= ~blink_on;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                FLASH: begin
                    if (frame_begin) begin
                        flash_on <= ~flash_on;
                        if (flash_cnt == FLASH_LAST) begin
                            state     <= HOLD;
                            sel_valid <= 1'b1;
                            flash_cnt <= '0;
                        end else begin
                            flash_cnt <= flash_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (sel_ack) begin
                        state     <= NAV;
                        sel_valid <= 1'b0;
                    end
                end
                default: state <= NAV;
            endcase
        end
    end

    // Row geometry is evaluated at 10 bits so the row top never wraps for any legal row.
    logic [CW-1:0] row_top;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic          cursor_vis;
    logic          on_glyph;
    logic          on_band;
    logic          band_on;
    logic [15:0]   pixel;

    assign px         = CW'(x);
    assign py         = CW'(y);
    assign row_top    = CW'(ITEM_Y0) + CW'(cursor_idx) * CW'(ITEM_PITCH);
    assign cursor_vis = (state != NAV) || blink_on;
    assign on_glyph   = ((px == CW'(CURSOR_X)) &&
                         ((py == row_top + CW'(1)) || (py == row_top + CW'(3)))) ||
                        ((px == CW'(CURSOR_X + 1)) && (py == row_top + CW'(2)));
    assign on_band    = (py >= row_top) && (py <= row_top + CW'(ITEM_H - 1)) &&
                        (px >= CW'(HL_X0)) && (px <= CW'(HL_X1));
    assign band_on    = !((state == FLASH) && !flash_on);

    // NOTE: pixel gets a default before the priority chain so no latch is inferred.
    always_comb begin
        pixel = BG_COLOUR;
        if (cursor_vis && on_glyph)
            pixel = CUR_COLOUR;
        else if (label_px)
            pixel = FG_COLOUR;
        else if (on_band && band_on)
            pixel = HL_COLOUR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            oled_data <= 16'h0000;
        else
            oled_data <= pixel;
    end

endmodule

// File: tb/tb_menu_screen_ctrl.sv
// Self-checking bench for menu_screen_ctrl: vector table, directed blink/flash/hold/reset
// sequences and a randomized run, all scored against a behavioural menu model.
module tb_menu_screen_ctrl;

    localparam logic [15:0] C_FG  = 16'hFFFF;
    localparam logic [15:0] C_HL  = 16'h001F;
    localparam logic [15:0] C_BG  = 16'h0000;
    localparam logic [15:0] C_CUR = 16'h07E0;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  x;
    logic [5:0]  y;
    logic        label_px;
    logic        frame_begin;
    logic        btn_up;
    logic        btn_down;
    logic        btn_sel;
    logic        sel_ack;
    logic [15:0] oled_data;
    logic [2:0]  cursor_idx;
    logic        sel_valid;
    logic [2:0]  sel_idx;

    int total = 0;
    int bad   = 0;

    menu_screen_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .label_px    (label_px),
        .frame_begin (frame_begin),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_sel     (btn_sel),
        .sel_ack     (sel_ack),
        .oled_data   (oled_data),
        .cursor_idx  (cursor_idx),
        .sel_valid   (sel_valid),
        .sel_idx     (sel_idx)
    );

    always #5 clk = ~clk;

    // Behavioural model: the menu as a few flags and counters.
    int m_rows        = 4;
    int m_cursor;
    bit m_blink_on;
    int m_blink_frames;
    bit m_flashing;
    bit m_holding;
    bit m_flash_on;
    int m_flash_frames;
    bit m_valid;
    int m_sel;

    task automatic model_reset();
        m_cursor       = 0;
        m_blink_on     = 1'b1;
        m_blink_frames = 0;
        m_flashing     = 1'b0;
        m_holding      = 1'b0;
        m_flash_on     = 1'b0;
        m_flash_frames = 0;
        m_valid        = 1'b0;
        m_sel          = 0;
    endtask

    function automatic logic [15:0] model_pixel(int px, int py, bit lp);
        int top;
        bit visible;
        bit glyph;
        bit band;
        top     = 28 + m_cursor * 8;
        visible = m_flashing || m_holding || m_blink_on;
        glyph   = (px == 18 && (py == top + 1 || py == top + 3)) || (px == 19 && py == top + 2);
        band    = px >= 20 && px <= 83 && py >= top && py < top + 5;
        if (visible && glyph)                     return C_CUR;
        if (lp)                                   return C_FG;
        if (band && !(m_flashing && !m_flash_on)) return C_HL;
        return C_BG;
    endfunction

    task automatic model_update(input bit up, input bit dn, input bit sl, input bit ak, input bit fb);
        if (m_holding) begin
            if (ak) begin
                m_holding = 1'b0;
                m_valid   = 1'b0;
            end
        end else if (m_flashing) begin
            if (fb) begin
                m_flash_on = !m_flash_on;
                m_flash_frames++;
                if (m_flash_frames == 8) begin
                    m_flashing = 1'b0;
                    m_holding  = 1'b1;
                    m_valid    = 1'b1;
                end
            end
        end else if (sl) begin
            m_flashing     = 1'b1;
            m_sel          = m_cursor;
            m_flash_frames = 0;
            m_flash_on     = 1'b1;
        end else if (up != dn) begin
            m_cursor       = dn ? (m_cursor + 1) % m_rows : (m_cursor + m_rows - 1) % m_rows;
            m_blink_on     = 1'b1;
            m_blink_frames = 0;
        end else if (fb) begin
            m_blink_frames++;
            if (m_blink_frames == 16) begin
                m_blink_frames = 0;
                m_blink_on     = !m_blink_on;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input logic [15:0] exp_pix);
        check("oled_vs_model",   32'(oled_data),  32'(exp_pix));
        check("cursor_vs_model", 32'(cursor_idx), 32'(m_cursor));
        check("valid_vs_model",  32'(sel_valid),  32'(m_valid));
        check("selidx_vs_model", 32'(sel_idx),    32'(m_sel));
    endtask

    // One clock: drive inputs, predict, clock, then compare everything against the model.
    task automatic step(input bit up, input bit dn, input bit sl, input bit ak, input bit fb,
                        input int px, input int py, input bit lp);
        logic [15:0] exp_pix;
        btn_up      = up;
        btn_down    = dn;
        btn_sel     = sl;
        sel_ack     = ak;
        frame_begin = fb;
        x           = 7'(px);
        y           = 6'(py);
        label_px    = lp;
        exp_pix     = model_pixel(px, py, lp);
        @(posedge clk);
        model_update(up, dn, sl, ak, fb);
        #1;
        check_model(exp_pix);
    endtask

    task automatic idle(input int px, input int py, input bit lp);
        step(0, 0, 0, 0, 0, px, py, lp);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("reset_async_valid",  32'(sel_valid),  32'd0);
        check("reset_async_cursor", 32'(cursor_idx), 32'd0);
        check("reset_async_oled",   32'(oled_data),  32'(C_BG));
        #2 reset = 1'b0;
    endtask

    typedef struct {
        bit          up;
        bit          dn;
        bit          sl;
        bit          ak;
        int          px;
        int          py;
        bit          lp;
        logic [15:0] pix;
        int          cur;
        bit          vld;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 18, 29, 0, C_CUR, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 40, 30, 0, C_HL,  0, 0};
        vecs[2]  = '{0, 0, 0, 0, 40, 30, 1, C_FG,  0, 0};
        vecs[3]  = '{0, 0, 0, 0, 18, 29, 1, C_CUR, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 40, 27, 0, C_BG,  0, 0};
        vecs[5]  = '{0, 0, 0, 0, 40, 32, 0, C_HL,  0, 0};
        vecs[6]  = '{1, 0, 0, 0,  0,  0, 0, C_BG,  3, 0};
        vecs[7]  = '{0, 1, 0, 0, 19, 54, 0, C_CUR, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 19, 30, 0, C_CUR, 1, 0};
        vecs[9]  = '{1, 1, 0, 0, 40, 36, 0, C_HL,  1, 0};
        vecs[10] = '{0, 0, 0, 0, 40, 41, 0, C_BG,  1, 0};
        vecs[11] = '{0, 0, 0, 0, 83, 40, 0, C_HL,  1, 0};
        vecs[12] = '{0, 0, 0, 0, 84, 40, 0, C_BG,  1, 0};
        vecs[13] = '{0, 0, 0, 0, 20, 36, 0, C_HL,  1, 0};
        vecs[14] = '{0, 0, 0, 0, 19, 36, 0, C_BG,  1, 0};
        vecs[15] = '{0, 0, 0, 1, 18, 37, 0, C_CUR, 1, 0};
        vecs[16] = '{0, 0, 0, 0, 18, 39, 0, C_CUR, 1, 0};

        reset       = 1'b1;
        x           = '0;
        y           = '0;
        label_px    = 1'b0;
        frame_begin = 1'b0;
        btn_up      = 1'b0;
        btn_down    = 1'b0;
        btn_sel     = 1'b0;
        sel_ack     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_oled",   32'(oled_data),  32'(C_BG));
        check("reset_cursor", 32'(cursor_idx), 32'd0);
        check("reset_valid",  32'(sel_valid),  32'd0);
        check("reset_selidx", 32'(sel_idx),    32'd0);
        reset = 1'b0;

        // Vector table
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].up, vecs[i].dn, vecs[i].sl, vecs[i].ak, 1'b0,
                 vecs[i].px, vecs[i].py, vecs[i].lp);
            check($sformatf("vec%0d_oled", i),   32'(oled_data),  32'(vecs[i].pix));
            check($sformatf("vec%0d_cursor", i), 32'(cursor_idx), 32'(vecs[i].cur));
            check($sformatf("vec%0d_valid", i),  32'(sel_valid),  32'(vecs[i].vld));
        end

        // Blink: cursor on row 1 stays lit for 15 frames, goes dark on the 16th, back after 16 more
        frames(15);
        idle(18, 37, 0);
        check("blink_15_visible", 32'(oled_data), 32'(C_CUR));
        frames(1);
        idle(18, 37, 0);
        check("blink_16_hidden", 32'(oled_data), 32'(C_BG));
        idle(18, 37, 1);
        check("blink_hidden_label", 32'(oled_data), 32'(C_FG));
        idle(40, 36, 0);
        check("blink_hidden_band", 32'(oled_data), 32'(C_HL));
        frames(15);
        idle(18, 37, 0);
        check("blink_31_hidden", 32'(oled_data), 32'(C_BG));
        frames(1);
        idle(18, 37, 0);
        check("blink_32_visible", 32'(oled_data), 32'(C_CUR));

        // Select with cursor hidden: flash forces the cursor visible and blinks the band
        step(0, 1, 0, 0, 0, 0, 0, 0);
        frames(16);
        idle(18, 45, 0);
        check("pre_sel_cursor_hidden", 32'(oled_data), 32'(C_BG));
        step(0, 1, 1, 0, 0, 0, 0, 0);
        check("sel_cursor", 32'(cursor_idx), 32'd2);
        check("sel_idx",    32'(sel_idx),    32'd2);
        check("sel_valid0", 32'(sel_valid),  32'd0);
        idle(18, 45, 0);
        check("flash_cursor_forced", 32'(oled_data), 32'(C_CUR));
        idle(40, 46, 0);
        check("flash_band_first", 32'(oled_data), 32'(C_HL));
        for (int k = 1; k <= 8; k++) begin
            step(k % 2 == 1, 0, 0, 0, 1, 0, 0, 0);
            idle(40, 46, 0);
            check($sformatf("flash%0d_band", k), 32'(oled_data),
                  32'((k % 2 == 1 && k < 8) ? C_BG : C_HL));
            check($sformatf("flash%0d_valid", k), 32'(sel_valid), 32'(k == 8));
            check($sformatf("flash%0d_cursor", k), 32'(cursor_idx), 32'd2);
        end

        // Hold: buttons ignored until ack, then navigation resumes
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("hold_ignore_down", 32'(cursor_idx), 32'd2);
        check("hold_valid",       32'(sel_valid),  32'd1);
        check("hold_selidx",      32'(sel_idx),    32'd2);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        check("ack_valid_drop", 32'(sel_valid), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("nav_after_ack", 32'(cursor_idx), 32'd3);

        // Reset during FLASH, then during HOLD
        step(0, 0, 1, 0, 0, 0, 0, 0);
        frames(1);
        pulse_reset();
        step(0, 0, 1, 0, 0, 0, 0, 0);
        frames(8);
        check("hold_before_reset", 32'(sel_valid), 32'd1);
        pulse_reset();

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            int px;
            int py;
            px = ($urandom % 2 == 1) ? 16 + int'($urandom % 6) : int'($urandom % 96);
            py = ($urandom % 2 == 1) ? 26 + int'($urandom % 36) : int'($urandom % 64);
            step($urandom % 8 == 0, $urandom % 8 == 0, $urandom % 12 == 0,
                 $urandom % 6 == 0, $urandom % 3 == 0, px, py, $urandom % 4 == 0);
        end

        idle(0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
